flt_to_fxd_pipe: RTL
====================

# flt_to_fxd_pipe

Pipelined IEEE-754 single-precision to Q1.20 fixed-point converter. It sits on the input side of the CORDIC datapath as the counterpart of the fixed-to-float output converter. The block is driven through the Nios II multi-cycle custom-instruction handshake and accepts one conversion per enabled cycle. It produces a 21-bit unsigned magnitude plus sign and range flags, so the CORDIC core receives a clean fixed-point operand.

## Interface
- No parameters. Widths are fixed: 32-bit float in, 21-bit Q1.20 out.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-high; clears all pipeline state.
- `clk_en` in 1: global enable; when 0 every stage holds its contents.
- `start` in 1: the `dataa` operand is valid this cycle (sampled only when `clk_en`=1).
- `dataa` in 32: IEEE-754 single operand.
- `done` out 1: `result`/flags valid this cycle; one pulse per accepted `start`.
- `result` out 21: Q1.20 unsigned magnitude (LSB = 2^-20).
- `sign` out 1: copy of `dataa[31]` for the operand now completing.
- `ovf` out 1: magnitude ≥ 2.0 after rounding, or Inf/NaN; `result` saturated.
- `uflow` out 1: operand was nonzero but `result` is 0.

## Operation
- Three register stages: S1 unpack/classify, S2 align shift, S3 round/saturate.
- Each stage carries a valid bit. S1's valid bit is loaded from `start`.
- S1:
  - exp = `dataa[30:23]`, mant = {1, `dataa[22:0]`} (24 bit).
  - Classify: zero/denormal (exp=0, flushed to zero); special (exp=255); big (exp ≥ 128); normal otherwise.
- S2:
  - Shift s = 130 − exp, computed 9-bit unsigned; valid only for normal operands.
  - q = mant >> s.
  - guard = bit s−1 of mant.
  - sticky = OR of mant bits below s−1.
  - If s ≥ 26: q=0, guard=0, sticky=1.
  - q is 22 bits wide, with a spare MSB to catch round-up carry.
- S3:
  - Apply rounding (see Configuration).
  - If big, special, or rounded q ≥ 2^21: `result`=21'h1FFFFF, `ovf`=1.
  - Zero/denormal: `result`=0, `ovf`=0, `uflow`=0.
  - Normal operand with final `result`=0: `uflow`=1.
- `sign` is the raw sign bit; negative operands yield the magnitude plus `sign`=1. -0.0 gives `sign`=1, `result`=0, `uflow`=0.
- The flags are meaningful only when `done`=1. They are held, not cleared, between operations.

## Timing
- Latency: with `clk_en` held at 1, `start` at edge N gives `done`=1 in the cycle after edge N+3 (3 edges).
- Throughput: one operand per enabled cycle; back-to-back `start` gives back-to-back `done`.
- `done` is registered. It is high for exactly one enabled cycle per operation, and only if the next stage-3 load has no valid operand.
- Stall: while `clk_en`=0:
  - no stage advances;
  - `start` and `dataa` are ignored;
  - `done`, `result` and the flags hold their last values.
- Simultaneous `start` with a stage-3 output: both proceed; there are no bubbles and no backpressure.
- Reset (asynchronous, any time including mid-pipeline):
  - all valid bits are set to 0;
  - `done`, `result`, `sign`, `ovf`, `uflow` are set to 0;
  - in-flight operands are discarded and never produce `done`.
- First operand after reset deassertion sees the full 3-cycle latency.

## Configuration
- `FLT2FXD_ROUND_EN`
  - Defined: round-to-nearest-even. Increment q when guard & (sticky | q[0]). A carry into bit 21 triggers saturation and `ovf`.
  - Undefined: truncate. q is used as is, guard/sticky logic is removed, and `ovf` depends only on classification.
  - Latency and handshake are identical in both builds.

## Test plan
- Basic: `dataa`=0x3F800000 (1.0) → 3 edges later `done`=1, `result`=0x100000, `sign`=0, `ovf`=0; 0x3F000000 (0.5) → 0x080000.
- Sign/zero:
  - 0xBF400000 (−0.75) → `result`=0x0C0000, `sign`=1.
  - 0x80000000 → `result`=0, `sign`=1, `uflow`=0.
  - 0x00000001 (denormal) → `result`=0, `uflow`=0.
- Range:
  - 0x40000000 (2.0) → `result`=0x1FFFFF, `ovf`=1.
  - 0x7FC00000 (NaN) → `ovf`=1.
  - 0x33000000 (2^−25) → `result`=0, `uflow`=1.
- Rounding:
  - 0x3F800006 → 0x100001 with `FLT2FXD_ROUND_EN`, 0x100000 without.
  - 0x3F800004 (exact tie) → 0x100000 in both builds.
  - 0x3FFFFFFF → ROUND_EN: 0x1FFFFF with `ovf`=1; no ROUND_EN: 0x1FFFFF with `ovf`=0.
- Stream/stall:
  - 6 back-to-back `start`s → 6 consecutive `done`s in order.
  - Drop `clk_en` for 4 cycles mid-stream → outputs frozen, no lost or duplicated results.
- Reset: assert `reset` with 2 operands in flight → all outputs 0 immediately. No `done` appears for those operands. The next `start` completes after 3 edges.

Source files
------------

// File: rtl/flt_to_fxd_pipe_if.sv
// rtl/flt_to_fxd_pipe_if.sv - custom-instruction handshake bundle for the float to Q1.20 converter
//
// Signals:
//   clk_en  global enable, 0 freezes the whole pipeline
//   start   dataa holds a valid operand this cycle
//   dataa   IEEE-754 single-precision operand
//   done    result and flags valid (one pulse per accepted start)
//   result  Q1.20 unsigned magnitude, LSB = 2^-20
//   sign    raw sign bit of the completing operand
//   ovf     magnitude >= 2.0 after rounding, or Inf/NaN (result saturated)
//   uflow   nonzero normal operand that came out as 0
// Modports: master drives the operand side, slave is the converter.

interface flt_to_fxd_pipe_if;
    logic        clk_en;
    logic        start;
    logic [31:0] dataa;
    logic        done;
    logic [20:0] result;
    logic        sign;
    logic        ovf;
    logic        uflow;

    modport master (
        output clk_en, start, dataa,
        input  done, result, sign, ovf, uflow
    );

    modport slave (
        input  clk_en, start, dataa,
        output done, result, sign, ovf, uflow
    );
endinterface

// File: rtl/flt_to_fxd_pipe.sv
// rtl/flt_to_fxd_pipe.sv - three-stage IEEE-754 single to Q1.20 fixed-point converter
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears valid bits and all outputs
//   ci     flt_to_fxd_pipe_if.slave (clk_en, start, dataa -> done, result, sign, ovf, uflow)
// Stages: S1 unpack/classify, S2 align shift, S3 round/saturate (output registers).
// Build option: define FLT2FXD_ROUND_EN for round-to-nearest-even; otherwise truncate.

module flt_to_fxd_pipe (
    input  logic               clk,
    input  logic               reset,
    flt_to_fxd_pipe_if.slave   ci
);

    // ---------------- S1: unpack / classify ----------------
    logic        s1_valid;
    logic        s1_sign;
    logic [7:0]  s1_exp;
    logic [23:0] s1_mant;
    logic        s1_zero;     // exp == 0: zero or denormal, flushed
    logic        s1_big;      // exp >= 128: |x| >= 2.0, also covers Inf/NaN (exp == 255)

    // ---------------- S2: align ----------------
    logic        s2_valid;
    logic        s2_sign;
    logic        s2_zero;
    logic        s2_big;
    logic [21:0] s2_q;        // bit 21 is spare headroom for the rounding carry
`ifdef FLT2FXD_ROUND_EN
    logic        s2_guard;
    logic        s2_sticky;
`endif

    // Value = mant * 2^(exp-150); in Q1.20 units that is mant * 2^(exp-130).
    // For normal operands (exp 1..127) the right shift is 3..129.
    logic [8:0]  shift_amt;
    logic [21:0] q_next;
    assign shift_amt = 9'd130 - {1'b0, s1_exp};

`ifdef FLT2FXD_ROUND_EN
    logic        far_shift;
    logic [47:0] shifted;
    logic        guard_next;
    logic        sticky_next;

    // mant is placed above 26 zero bits so that, for shifts up to 25, the bits
    // dropped below the integer part land in [25:0]: [25] is guard, the rest sticky.
    // The top two bits of the 50-bit shift are always zero (shift >= 3) and dropped.
    assign far_shift   = (shift_amt >= 9'd26);
    assign shifted     = 48'({s1_mant, 26'b0} >> shift_amt);
    assign q_next      = far_shift ? 22'd0 : shifted[47:26];
    assign guard_next  = far_shift ? 1'b0  : shifted[25];
    assign sticky_next = far_shift ? 1'b1  : (|shifted[24:0]);
`else
    // The 24-bit shift discards bits naturally; shifts >= 24 give 0.
    // The top two bits dropped by the cast are zero because the shift is >= 3.
    assign q_next = 22'(s1_mant >> shift_amt);
`endif

    // ---------------- S3: round / saturate ----------------
    logic [21:0] q_rnd;
    logic        sat;
    logic [20:0] result_next;
    logic        uflow_next;

`ifdef FLT2FXD_ROUND_EN
    // Round to nearest, ties to even.
    assign q_rnd = s2_q + {21'd0, s2_guard & (s2_sticky | s2_q[0])};
`else
    assign q_rnd = s2_q;
`endif

    assign sat         = s2_big | q_rnd[21];
    assign result_next = sat     ? 21'h1FFFFF :
                         s2_zero ? 21'd0      : q_rnd[20:0];
    assign uflow_next  = ~s2_zero & ~sat & (q_rnd[20:0] == 21'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_exp    <= 8'd0;
            s1_mant   <= 24'd0;
            s1_zero   <= 1'b0;
            s1_big    <= 1'b0;
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_zero   <= 1'b0;
            s2_big    <= 1'b0;
            s2_q      <= 22'd0;
`ifdef FLT2FXD_ROUND_EN
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
`endif
            ci.done   <= 1'b0;
            ci.result <= 21'd0;
            ci.sign   <= 1'b0;
            ci.ovf    <= 1'b0;
            ci.uflow  <= 1'b0;
        end else if (ci.clk_en) begin
            s1_valid <= ci.start;
            if (ci.start) begin
                s1_sign <= ci.dataa[31];
                s1_exp  <= ci.dataa[30:23];
                s1_mant <= {1'b1, ci.dataa[22:0]};
                s1_zero <= (ci.dataa[30:23] == 8'd0);
                s1_big  <= ci.dataa[30];
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign   <= s1_sign;
                s2_zero   <= s1_zero;
                s2_big    <= s1_big;
                s2_q      <= q_next;
`ifdef FLT2FXD_ROUND_EN
                s2_guard  <= guard_next;
                s2_sticky <= sticky_next;
`endif
            end

            // Outputs only change when an operand completes; flags are held otherwise.
            ci.done <= s2_valid;
            if (s2_valid) begin
                ci.result <= result_next;
                ci.sign   <= s2_sign;
                ci.ovf    <= sat;
                ci.uflow  <= uflow_next;
            end
        end
    end

endmodule
